// File: rtl/activation_stream_arbiter.sv
// Round-robin burst arbiter sharing one activation unit between NUM_REQ streams.
// Issued beats are tagged with their requester so in-order results can be routed back.
module activation_stream_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARALLELISM  = 1,
    parameter int unsigned BURST_LEN    = 10,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0][PARALLELISM*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]                act_in_data,
    output logic                                             act_in_valid,
    input  logic                                             act_in_ready,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]                act_out_data,
    input  logic                                             act_out_valid,
    output logic                                             act_out_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]                resp_data,
    output logic [NUM_REQ-1:0]                               resp_valid,
    input  logic [NUM_REQ-1:0]                               resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                       grant_id,
    output logic                                             busy,
    output logic                                             err
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned AW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CW   = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      rr_q, rr_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdW-1:0]      winner, cand;
    logic                any_req;
    logic                in_hs, out_hs;

    logic [IdW-1:0]      tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                tag_full, tag_empty;
    logic [IdW-1:0]      head;
    logic                err_q;

    // Search starts just after the last winner, so it is considered last.
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdW'((32'(rr_q) + i) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rr_q    <= IdW'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = winner;
                    rr_d    = winner;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (in_hs) begin
                    if (cnt_q == CntW'(BURST_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        act_in_data  = '0;
        act_in_valid = 1'b0;
        req_ready    = '0;
        busy         = 1'b0;
        if (state_q == StBurst) begin
            busy               = 1'b1;
            act_in_data        = req_data[grant_q];
            act_in_valid       = req_valid[grant_q] && !tag_full;
            req_ready[grant_q] = act_in_ready && !tag_full;
        end
    end

    assign in_hs    = act_in_valid && act_in_ready;
    assign grant_id = grant_q;

    // Return path: the tag at the FIFO head names the owner of the next result.
    assign tag_full  = (count_q == CW'(MAX_INFLIGHT));
    assign tag_empty = (count_q == '0);
    assign head      = tag_mem[rd_ptr_q];

    always_comb begin
        resp_data     = act_out_data;
        resp_valid    = '0;
        act_out_ready = 1'b0;
        if (!tag_empty) begin
            resp_valid[head] = act_out_valid;
            act_out_ready    = resp_ready[head];
        end
    end

    assign out_hs = act_out_valid && act_out_ready;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (in_hs) begin
            tag_mem[wr_ptr_q] <= grant_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_hs) begin
                wr_ptr_q <= (wr_ptr_q == AW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (out_hs) begin
                rd_ptr_q <= (rd_ptr_q == AW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({in_hs, out_hs})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (act_out_valid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/activation_stream_arbiter.md
Name: activation_stream_arbiter

Overview:
- Shares one fixed-point activation unit (logsigmoid/sigmoid/etc. pipeline with valid/ready on both sides) between NUM_REQ independent tensor streams.
- Grants one requester at a time for a full tensor burst of BURST_LEN beats, using round-robin arbitration.
- Tags every beat it issues, then routes each result beat back to the requester that issued it.
- Sits between the per-layer stream producers/consumers and a single shared activation instance.

Parameters:
- NUM_REQ, 4, number of requester streams (>=2).
- DATA_WIDTH, 8, bits per element.
- PARALLELISM, 1, elements per beat.
- BURST_LEN, 10, beats per granted burst (tensor depth), >=1.
- MAX_INFLIGHT, 8, tag FIFO depth (power of 2); bounds the beats outstanding inside the shared unit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_data  in  [NUM_REQ][PARALLELISM*DATA_WIDTH]  per-requester input beat.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready.
- act_in_data  out  PARALLELISM*DATA_WIDTH  beat to shared unit.
- act_in_valid  out  1  valid to shared unit.
- act_in_ready  in  1  ready from shared unit.
- act_out_data  in  PARALLELISM*DATA_WIDTH  result from shared unit.
- act_out_valid  in  1  result valid.
- act_out_ready  out  1  result ready.
- resp_data  out  PARALLELISM*DATA_WIDTH  result broadcast to all requesters.
- resp_valid  out  NUM_REQ  one-hot result valid.
- resp_ready  in  NUM_REQ  per-requester result ready.
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester.
- busy  out  1  high in BURST state.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; rr pointer=NUM_REQ-1; beat counter=0; tag FIFO empty; grant_id=0; err=0.
  - All valid/ready outputs are 0.
  - In-flight beats are discarded. The shared unit must be reset by the same rst.
- IDLE:
  - If any req_valid is high, pick the first requester with req_valid high, searching from rr+1 upward with wrap.
  - Register the winner as grant_id and into rr; next cycle state=BURST.
  - Arbitration costs one bubble cycle. No req_ready is asserted in IDLE.
- BURST:
  - act_in_data = req_data[grant_id].
  - act_in_valid = req_valid[grant_id] && !tag_full.
  - req_ready[grant_id] = act_in_ready && !tag_full; all other req_ready are 0.
  - Each act_in handshake pushes grant_id into the tag FIFO and increments the counter.
  - On the handshake with counter==BURST_LEN-1: counter<=0, state<=IDLE.
  - Grant is never revoked mid-burst. A stalled requester holds the unit.
- Tag FIFO full blocks a push even if a pop occurs in the same cycle. Simultaneous push and pop when not full keeps the count unchanged.
- Return path (combinational routing, no added latency):
  - head = tag FIFO head.
  - resp_data = act_out_data.
  - resp_valid[head] = act_out_valid && !tag_empty; all other resp_valid bits are 0.
  - act_out_ready = resp_ready[head] && !tag_empty.
  - Handshake pops the FIFO.
- Results return in issue order; the shared unit is required to be in-order.
- act_out_valid while the tag FIFO is empty sets err=1 until reset; the beat is not accepted.
- Round-robin fairness: a requester that just finished a burst is searched last next time.
- With NUM_REQ requesters all continuously valid, grants rotate 0,1,2,3,0,...
- Latency from req handshake to resp_valid equals the shared unit latency; the arbiter adds 0 cycles on the data path.

Test Plan:
- Reset, then req_valid=4'b0100 -> grant_id=2 one cycle later, busy=1; exactly 10 beats accepted (BURST_LEN=10); busy=0 after the 10th handshake.
- req_valid=4'b1111 held, 3 bursts -> grant order 0,1,2; no req_ready to non-granted requesters; one idle cycle between bursts.
- Shared unit modelled as 3-cycle pipeline, act_out_ready stalls; requester 1 holds resp_ready=0 -> tag FIFO fills to 8; act_in_valid=0 and req_ready=0 until a pop; no beat lost or reordered.
- Burst from requester 3 followed by requester 0, results overlapping in flight -> resp_valid one-hot switches from 4'b1000 to 4'b0001 exactly at the 11th result; resp_data matches the golden model.
- act_out_valid pulsed with empty tag FIFO -> err=1 and stays 1; act_out_ready=0; reset clears err.
- rst pulsed low mid-burst (counter=5, 3 beats in flight) -> all outputs 0 immediately; after release state=IDLE and the tag FIFO is empty; the next grant starts from requester rr+1 = 0.
